// File: rtl/memory4c_resp_if.sv
// Request/response bundle between an initiator (CPU fetch/data or cache fill)
// and the pipelined memory responder.
interface memory4c_resp_if #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned AWIDTH = 16
);
  logic              enable;
  logic              wr;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] data_in;
  logic [DWIDTH-1:0] data_out;
  logic              data_valid;
  logic              busy;
  logic [3:0]        outstanding;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, busy, outstanding
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, busy, outstanding
  );
endinterface

// File: rtl/memory4c_resp.sv
// Multi-cycle main-memory responder: writes commit on accept, reads return a
// snapshot of the addressed word exactly LATENCY cycles after the request.
module memory4c_resp #(
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned AWIDTH     = 16,
  parameter int unsigned DEPTH_LOG2 = 15,
  parameter int unsigned LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  memory4c_resp_if.slave    bus
);

  localparam int unsigned Words = 2 ** DEPTH_LOG2;

  if (LATENCY < 2 || LATENCY > 8) begin : g_bad_latency
    $error("memory4c_resp: LATENCY must be within 2..8");
  end
  if (DEPTH_LOG2 > AWIDTH - 1) begin : g_bad_depth
    $error("memory4c_resp: DEPTH_LOG2 must not exceed AWIDTH-1");
  end

  logic [DWIDTH-1:0]     r_mem [Words];
  logic [LATENCY-1:0]    r_vld;
  logic [DWIDTH-1:0]     r_pipe [LATENCY];
  logic [3:0]            r_cnt;

  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_pop;
  logic [AWIDTH-1:0]     w_unused_addr;

  // Bit 0 and anything above the stored depth alias onto the same word.
  assign w_idx         = bus.addr[DEPTH_LOG2:1];
  assign w_unused_addr = bus.addr;
  assign w_rd          = bus.enable & ~bus.wr;
  assign w_wr          = bus.enable & bus.wr;
  assign w_pop         = r_vld[LATENCY-1];

  // Storage is never cleared; requests seen while in reset must not write it.
  always_ff @(posedge clk) begin
    if (rst && w_wr) begin
      r_mem[w_idx] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_vld <= {r_vld[LATENCY-2:0], w_rd};
      if (w_rd) begin
        r_pipe[0] <= r_mem[w_idx];
      end
      for (int i = 1; i < LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  // Reads in flight: a simultaneous accept and retire leave the count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else begin
      unique case ({w_rd, w_pop})
        2'b10:   r_cnt <= r_cnt + 4'd1;
        2'b01:   r_cnt <= r_cnt - 4'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign bus.data_valid  = r_vld[LATENCY-1];
  assign bus.data_out    = r_vld[LATENCY-1] ? r_pipe[LATENCY-1] : '0;
  assign bus.outstanding = r_cnt;
  assign bus.busy        = (r_cnt != 4'd0);

endmodule

// File: tb/tb_memory4c_resp.sv
// Directed and random checks of memory4c_resp against a queue-based model
// of word storage and read-return timing.
module tb_memory4c_resp;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 16;
  localparam int unsigned DL  = 15;
  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  typedef struct {
    int          due;
    logic [DW-1:0] d;
  } rd_t;

  logic [DW-1:0] mdl_mem [int];
  rd_t           rq[$];

  always #5 clk = ~clk;

  memory4c_resp_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  memory4c_resp #(
    .DWIDTH    (DW),
    .AWIDTH    (AW),
    .DEPTH_LOG2(DL),
    .LATENCY   (LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow from the model: a return is due LATENCY-1 edges
  // after its accept edge, and every queued read counts as outstanding.
  task automatic chk_outputs();
    logic ev;
    ev = (rq.size() > 0) && (rq[0].due == cyc);
    chk("data_valid", 32'(bus.data_valid), 32'(ev));
    if (ev) chk("data_out", 32'(bus.data_out), 32'(rq[0].d));
    else if (!rst) chk("data_out_rst", 32'(bus.data_out), 32'd0);
    chk("outstanding", 32'(bus.outstanding), 32'(rq.size()));
    chk("busy", 32'(bus.busy), 32'(rq.size() != 0));
  endtask

  task automatic tick();
    int idx;
    @(posedge clk);
    if (rst) begin
      cyc++;
      if (bus.enable) begin
        idx = int'(bus.addr[DL:1]);
        if (bus.wr) mdl_mem[idx] = bus.data_in;
        else rq.push_back('{due: cyc + int'(LAT) - 1, d: mdl_mem[idx]});
      end
      while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
    end
    #1;
    chk_outputs();
  endtask

  task automatic drive(input logic en, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    bus.enable  = en;
    bus.wr      = w;
    bus.addr    = a;
    bus.data_in = d;
  endtask

  task automatic do_rd(input logic [AW-1:0] a);
    drive(1'b1, 1'b0, a, 16'($urandom));
    tick();
  endtask

  task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(1'b1, 1'b1, a, d);
    tick();
  endtask

  task automatic do_idle();
    drive(1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
    tick();
  endtask

  task automatic drain();
    repeat (LAT + 2) do_idle();
  endtask

  initial begin
    drive(1'b0, 1'b0, '0, '0);
    #2 rst = 1'b0;
    #1 chk_outputs();
    tick();
    tick();
    rst = 1'b1;

    // Preload through the write port.
    do_wr(16'h0020, 16'hBEEF);
    for (int i = 0; i < 8; i++) do_wr(16'(i * 2), 16'(i * 16'h1111));
    do_wr(16'h0080, 16'hAAAA);
    do_wr(16'h0600, 16'h0F0F);
    for (int i = 0; i < 32; i++) do_wr(16'((16'h0200 + i) * 2), 16'($urandom));

    // Single read: return in cycle 4.
    do_rd(16'h0020);
    chk("single_outst_c1", 32'(bus.outstanding), 32'd1);
    repeat (3) do_idle();
    chk("single_valid_c4", 32'(bus.data_valid), 32'd1);
    chk("single_data_c4", 32'(bus.data_out), 32'h0000BEEF);
    drain();

    // Write then read, including the bit-0 alias.
    do_wr(16'h0100, 16'h1234);
    do_rd(16'h0100);
    do_rd(16'h0101);
    repeat (2) do_idle();
    chk("wr_rd_data_c5", 32'(bus.data_out), 32'h00001234);
    drain();

    // Streaming reads of words 0..7.
    for (int i = 0; i < 8; i++) begin
      do_rd(16'(i * 2));
      if (i == 3) chk("stream_peak", 32'(bus.outstanding), 32'd4);
    end
    drain();

    // Read snapshot survives a later write to the same word.
    do_rd(16'h0080);
    do_wr(16'h0080, 16'h5555);
    repeat (2) do_idle();
    chk("snapshot_old", 32'(bus.data_out), 32'h0000AAAA);
    drain();
    do_rd(16'h0080);
    repeat (3) do_idle();
    chk("snapshot_new", 32'(bus.data_out), 32'h00005555);
    drain();

    // Reset asserted mid-cycle with reads in flight.
    do_rd(16'h0000);
    do_rd(16'h0002);
    drive(1'b1, 1'b0, 16'h0004, 16'h0000);
    #3 rst = 1'b0;
    rq.delete();
    #1 chk_outputs();
    chk("rst_outst_now", 32'(bus.outstanding), 32'd0);
    drive(1'b1, 1'b1, 16'h0600, 16'hDEAD);
    tick();
    tick();
    rst = 1'b1;
    repeat (8) do_idle();
    do_rd(16'h0600);
    repeat (3) do_idle();
    chk("rst_write_blocked", 32'(bus.data_out), 32'h00000F0F);
    drain();

    // Idle with junk on the don't-care inputs.
    for (int i = 0; i < 20; i++) begin
      do_idle();
      chk("idle_busy", 32'(bus.busy), 32'd0);
    end
    for (int i = 0; i < 8; i++) do_rd(16'(i * 2));
    drain();

    // Random traffic within the preloaded window.
    for (int i = 0; i < 400; i++) begin
      int unsigned op;
      logic [AW-1:0] a;
      op = $urandom_range(0, 3);
      a  = {15'(16'h0200 + $urandom_range(0, 31)), 1'($urandom)};
      if (op == 0) do_idle();
      else if (op == 1) do_wr(a, 16'($urandom));
      else do_rd(a);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/memory4c_resp.md
Name: memory4c_resp

Overview:
- Pipelined, multi-cycle main-memory responder for the WISC-FA24 processor.
- The CPU fetch/data path and the cache-fill logic are initiators; this block is the memory end of that request/response protocol.
- Accepts at most one read or write request per cycle. Each accepted read returns its 16-bit word exactly LATENCY cycles later with a valid strobe.
- Writes commit in the accept cycle.

Parameters:
DWIDTH, 16, data word width in bits
AWIDTH, 16, byte-address width; word index = addr[AWIDTH-1:1]
DEPTH_LOG2, 15, log2 of number of words stored (≤ AWIDTH-1)
LATENCY, 4, read latency in cycles from accept edge to data_valid (2..8)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset (asserted when 0)
enable  input  1  request valid this cycle
wr  input  1  1 = write, 0 = read; sampled only when enable=1
addr  input  AWIDTH  byte address; bit 0 ignored
data_in  input  DWIDTH  write data
data_out  output  DWIDTH  read return data, meaningful only when data_valid=1
data_valid  output  1  read return strobe, one cycle per accepted read
busy  output  1  1 while any read is in flight
outstanding  output  4  number of reads in flight (0..LATENCY)

Behaviour:
- Storage:
  - Array of 2^DEPTH_LOG2 words indexed by addr[DEPTH_LOG2:1].
  - Address bits above DEPTH_LOG2 are ignored (aliasing).
  - Not cleared by reset; simulation preloads via file load.
- Accept:
  - Every cycle with enable=1 is accepted. No backpressure; initiator never stalls.
- Write:
  - enable=1, wr=1: array[word] <= data_in at that rising edge.
  - No response is generated and the write does not enter the pipeline.
- Read:
  - enable=1, wr=0: array[word] is sampled at the accept edge into stage 1 of a LATENCY-deep shift pipeline (valid bit + data per stage).
  - data_valid/data_out are driven from the last stage. A read accepted at edge N produces data_valid=1 in the cycle following edge N+LATENCY-1, i.e. visible LATENCY cycles after the request cycle.
- Back-to-back reads:
  - A read every cycle yields data_valid every cycle after the initial latency, with results in issue order.
- Read/write ordering:
  - Read data is a snapshot at the accept edge.
  - A write accepted after a read to the same address does not alter that read's returned data.
  - A read accepted after a write (any later cycle) returns the new data.
  - A single cycle cannot carry both a read and a write.
- Counters:
  - outstanding = count of valid stages (pop-count of the pipeline valid bits, or an up/down counter: +1 on read accept, −1 on data_valid, both → unchanged).
  - busy = (outstanding != 0).
- Reset (rst=0, asynchronous):
  - Immediately clears all pipeline valid bits.
  - data_valid=0, data_out=0, outstanding=0, busy=0.
  - In-flight reads are discarded and never returned after reset deasserts.
  - Requests presented while rst=0 are ignored, including writes: the array is not written.
- Deassertion:
  - The first request is accepted at the first rising edge with rst=1.
- X handling:
  - When enable=0, wr/addr/data_in are don't-care and must not affect state.
- Illegal parameter values (LATENCY outside 2..8) are a compile-time error.

Test Plan:
- Reset then single read:
  - Preload array[0x0010]=0xBEEF.
  - Read addr=0x0020 issued in cycle 0 → data_valid=1, data_out=0xBEEF exactly in cycle 4. data_valid=0 in cycles 1–3 and 5.
  - outstanding=1 during cycles 1–3.
- Write then read:
  - Write addr=0x0100, data 0x1234 in cycle 0; read addr=0x0100 in cycle 1 → data_out=0x1234 with data_valid in cycle 5.
  - Also read addr=0x0101 → same word (bit 0 ignored).
- Streaming reads:
  - Reads of words 0..7 (preloaded with value=index*0x1111) on 8 consecutive cycles → data_valid high for 8 consecutive cycles from cycle 4, values 0x0000, 0x1111, …, 0x7777 in order.
  - outstanding peaks at 4.
- Read-then-write snapshot:
  - array[0x40]=0xAAAA.
  - Read addr=0x80 in cycle 0, write 0x5555 to addr=0x80 in cycle 1 → cycle-4 return is 0xAAAA.
  - A following read returns 0x5555.
- Reset mid-flight:
  - Issue 3 reads in cycles 0–2; assert rst=0 asynchronously mid-cycle 2 and release at cycle 4 → data_valid, outstanding, and busy go 0 immediately.
  - No data_valid ever appears for those reads.
  - A write presented during reset leaves the target word unchanged.
- Idle and don't-care inputs:
  - enable=0 with toggling wr/addr/data_in for 20 cycles → no array change, data_valid=0, busy=0 throughout.
